// File: rtl/ltc2601_x4.sv
// ltc2601_x4 -- SPI master for a daisy chain of four LTC2601 DACs.
//
// One trig pulse sends a 128-bit stream, made of four 32-bit words fetched
// from the parent's register file in the order addr 3, 2, 1, 0. The word
// for the DAC farthest down the chain therefore goes out first. Each word
// is captured at the end of a one-cycle LOAD state. During LOAD, flush
// tells the parent to overwrite the word at addr with NOP.
//
// Handshake: trig is a one-cycle request with no ready signal. It is
// accepted only in IDLE and ignored in every other state. busy is high
// from the cycle after acceptance until the machine is back in IDLE.
//
// Ports:
//   clkin      in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   trig       in   start one chain transaction
//   word[31:0] in   command word for the DAC selected by addr (combinational from parent)
//   addr[3:0]  out  index of the word being fetched or flushed
//   sclk       out  SPI clock, idle low, 4 clkin cycles per bit
//   csel       out  SPI chip select, active low
//   mosi       out  SPI data, MSB first, changes only while sclk is low
//   busy       out  transaction in progress
//   flush      out  one-cycle pulse, parent writes NOP to word[addr]
//   fsm_state  out  current FSM state (debug)
module ltc2601_x4 (
    input  logic        clkin,
    input  logic        reset,
    input  logic        trig,
    input  logic [31:0] word,
    output logic [3:0]  addr,
    output logic        sclk,
    output logic        csel,
    output logic        mosi,
    output logic        busy,
    output logic        flush,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] sr;
    logic [1:0]  phase;     // position inside a 4-cycle bit period
    logic [4:0]  bit_cnt;   // bit index within the current word
    logic        done_cnt;  // DONE lasts two cycles

    assign fsm_state = state;

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sr       <= 32'd0;
            phase    <= 2'd0;
            bit_cnt  <= 5'd0;
            done_cnt <= 1'b0;
            addr     <= 4'd3;
            sclk     <= 1'b0;
            csel     <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            flush    <= 1'b0;
        end else begin
            // flush is raised only on the transition into LOAD, so it lasts one cycle
            flush <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        csel  <= 1'b0;
                        flush <= 1'b1;
                        addr  <= 4'd3;
                    end
                end

                LOAD: begin
                    // The parent's NOP write lands on this same edge, so the
                    // word sampled here is still the pre-flush value.
                    sr      <= word;
                    mosi    <= word[31];
                    phase   <= 2'd0;
                    bit_cnt <= 5'd0;
                    sclk    <= 1'b0;
                    state   <= SHIFT;
                end

                SHIFT: begin
                    phase <= phase + 2'd1;
                    // Phases 0,1 low and 2,3 high. The register holds the
                    // value for the next cycle, so it rises after phase 1.
                    sclk  <= (phase == 2'd1) || (phase == 2'd2);
                    if (phase == 2'd3) begin
                        // End of the bit period: sclk falls and mosi moves on together.
                        sr <= {sr[30:0], 1'b0};
                        if (bit_cnt == 5'd31) begin
                            mosi <= 1'b0;
                            if (addr != 4'd0) begin
                                addr  <= addr - 4'd1;
                                flush <= 1'b1;
                                state <= LOAD;
                            end else begin
                                csel     <= 1'b1;
                                done_cnt <= 1'b0;
                                state    <= DONE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            mosi    <= sr[30];
                        end
                    end
                end

                DONE: begin
                    if (done_cnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        addr  <= 4'd3;
                    end else begin
                        done_cnt <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2601_x4.sv
// Testbench for ltc2601_x4: a parent register-file model plus a scoreboard
// of expected mosi bits and flush addresses.
module tb_ltc2601_x4;

  localparam logic [31:0] NOP = 32'h00F08000;

  // ---------------- clock / reset ----------------
  logic        clkin = 1'b0;
  logic        reset = 1'b0;
  logic        trig  = 1'b0;
  logic [31:0] word;
  logic [3:0]  addr;
  logic        sclk, csel, mosi, busy, flush;
  logic [1:0]  fsm_state;

  always #5 clkin = ~clkin;

  ltc2601_x4 dut (
    .clkin     (clkin),
    .reset     (reset),
    .trig      (trig),
    .word      (word),
    .addr      (addr),
    .sclk      (sclk),
    .csel      (csel),
    .mosi      (mosi),
    .busy      (busy),
    .flush     (flush),
    .fsm_state (fsm_state)
  );

  // ---------------- parent register file ----------------
  logic [31:0] regs     [4];
  logic [31:0] set_vals [4];
  logic        set_en = 1'b0;

  assign word = regs[addr[1:0]];

  always @(posedge clkin) begin
    if (set_en) begin
      for (int i = 0; i < 4; i++) regs[i] <= set_vals[i];
    end else if (flush) begin
      regs[addr[1:0]] <= NOP;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [0:0]  exp_q[$];
  logic [3:0]  addr_q[$];
  logic [31:0] model [4];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cyc, rise_cnt, flush_cnt, last_flush;
  int run_len  = 0;
  logic load_in_run = 1'b0;
  logic prev_sclk   = 1'b0;
  logic prev_mosi   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: outputs are sampled on the falling edge and monitored.
  task automatic tick();
    logic [0:0] eb;
    logic [3:0] ea;
    @(negedge clkin);
    cyc++;
    if (busy) busy_cyc++;

    if (flush) begin
      flush_cnt++;
      ea = (addr_q.size() > 0) ? addr_q.pop_front() : 4'hF;
      chk("flush_addr", addr, ea);
      chk("flush_busy", busy, 1);
      chk("flush_sclk_low", sclk, 0);
      if (last_flush >= 0) chk("flush_spacing", cyc - last_flush, 129);
      last_flush = cyc;
      model[addr[1:0]] = NOP;
    end

    if (sclk && !prev_sclk) begin
      rise_cnt++;
      eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      chk("mosi_bit", mosi, eb);
      chk("csel_low_at_rise", csel, 0);
    end

    if (sclk && prev_sclk) chk("mosi_stable_high", mosi, prev_mosi);

    if (!busy) begin
      run_len     = 0;
      load_in_run = 1'b0;
    end else if (sclk != prev_sclk) begin
      if (prev_sclk) chk("sclk_high_len", run_len, 2);
      else if (run_len > 0) chk("sclk_low_len", run_len, load_in_run ? 3 : 2);
      run_len     = 1;
      load_in_run = flush;
    end else begin
      run_len++;
      load_in_run = load_in_run | flush;
    end

    prev_sclk = sclk;
    prev_mosi = mosi;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_words(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    set_vals[0] = w0; set_vals[1] = w1; set_vals[2] = w2; set_vals[3] = w3;
    model[0] = w0; model[1] = w1; model[2] = w2; model[3] = w3;
    set_en = 1'b1;
    tick();
    set_en = 1'b0;
  endtask

  task automatic start_txn();
    for (int a = 3; a >= 0; a--) begin
      addr_q.push_back(4'(a));
      for (int b = 31; b >= 0; b--) exp_q.push_back(model[a][b]);
    end
    busy_cyc   = 0;
    rise_cnt   = 0;
    flush_cnt  = 0;
    last_flush = -1;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic run_to_idle(input int retrig_at, input string tag);
    for (int i = 0; i < 700 && busy; i++) begin
      if (i == retrig_at) trig = 1'b1;
      tick();
      trig = 1'b0;
    end
    chk({tag, "_timeout"}, busy, 0);
    chk({tag, "_busy_cycles"}, busy_cyc, 518);
    chk({tag, "_sclk_rises"}, rise_cnt, 128);
    chk({tag, "_flush_pulses"}, flush_cnt, 4);
    chk({tag, "_bits_left"}, exp_q.size(), 0);
    chk({tag, "_flush_left"}, addr_q.size(), 0);
    chk({tag, "_csel_idle"}, csel, 1);
    chk({tag, "_addr_idle"}, addr, 3);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_csel"}, csel, 1);
    chk({tag, "_sclk"}, sclk, 0);
    chk({tag, "_mosi"}, mosi, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_addr"}, addr, 3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hold_rise, hold_flush;

    // Reset state
    repeat (3) tick();
    check_idle("reset");
    reset = 1'b1;
    repeat (3) tick();
    check_idle("post_reset");

    // Reference transaction with the known words
    load_words(32'h00301111, 32'h00302222, 32'h00303333, 32'h00304444);
    start_txn();
    chk("start_busy", busy, 1);
    chk("start_csel", csel, 0);
    chk("start_flush", flush, 1);
    run_to_idle(-1, "txn1");

    // Immediate retrigger: parent flushed every word, so four NOPs go out.
    // A second trig 50 cycles in must be ignored.
    for (int i = 0; i < 4; i++) chk("model_nop", model[i], NOP);
    start_txn();
    run_to_idle(50, "txn_nop");
    repeat (5) tick();
    chk("no_restart_busy", busy, 0);

    // Reset in the middle of the stream (bit 70)
    load_words($urandom, $urandom, $urandom, $urandom);
    start_txn();
    for (int i = 0; i < 700 && rise_cnt < 70; i++) tick();
    chk("reached_bit70", rise_cnt, 70);
    reset = 1'b0;
    #1;
    check_idle("abort_now");
    exp_q.delete();
    addr_q.delete();
    hold_rise  = rise_cnt;
    hold_flush = flush_cnt;
    repeat (4) tick();
    reset = 1'b1;
    repeat (20) tick();
    chk("abort_no_sclk", rise_cnt, hold_rise);
    chk("abort_no_flush", flush_cnt, hold_flush);
    check_idle("abort_idle");

    // Fresh stream after abort: words 3..1 were flushed, word 0 is intact.
    start_txn();
    run_to_idle(-1, "txn_after_abort");

    // Random words
    load_words($urandom, $urandom, $urandom, $urandom);
    start_txn();
    run_to_idle(-1, "txn_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ltc2601_x4.md
LTC2601_X4 -- requirements
Module: ltc2601_x4

Interface
REQ-001 The block SHALL have no parameters; all timing below is fixed.
REQ-002 clkin  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 trig  input  1  single-cycle request to start one chain transaction.
REQ-005 word  input  32  command word for the DAC selected by addr; sourced combinationally by the parent from its register file.
REQ-006 addr  output  4  index (0-3) of the word being fetched or flushed.
REQ-007 sclk  output  1  SPI serial clock; idle low.
REQ-008 csel  output  1  SPI chip select, active low; idle high.
REQ-009 mosi  output  1  SPI serial data, MSB first.
REQ-010 busy  output  1  high from transaction start until return to idle.
REQ-011 flush  output  1  one-cycle pulse; the parent overwrites the word at addr with NOP while it is high.

Function
REQ-012 The design SHALL be a state machine with states IDLE, LOAD, SHIFT and DONE.
REQ-013 IDLE outputs: busy=0, csel=1, sclk=0, mosi=0, flush=0, addr=3.
REQ-014 In IDLE, trig=1 at a rising edge SHALL move to LOAD, set busy=1, drive csel=0 and hold addr=3.
REQ-015 trig SHALL be ignored in every state other than IDLE.
REQ-016 LOAD SHALL last exactly one cycle.
REQ-017 In LOAD, flush SHALL be 1 with busy=1 and addr stable.
REQ-018 At the edge ending LOAD, the 32-bit shift register SHALL capture word; the parent's concurrent NOP write SHALL not affect the captured value.
REQ-019 flush SHALL be 0 in every state other than LOAD.
REQ-020 SHIFT SHALL send 32 bits per word at 4 clkin cycles per bit.
REQ-021 Each bit period SHALL drive sclk low for 2 cycles, then high for 2 cycles.
REQ-022 mosi SHALL equal shift-register bit 31 and SHALL change only while sclk is low, so it is stable at the sclk rising edge (LTC2601 samples on rising edge).
REQ-023 The shift register SHALL shift left by one at the end of each bit period.
REQ-024 After 32 bits with addr>0, addr SHALL decrement by 1 and the machine SHALL return to LOAD.
REQ-025 After 32 bits with addr=0, the machine SHALL go to DONE.
REQ-026 Words SHALL be sent in the order addr 3, 2, 1, 0, giving a 128-bit daisy-chain stream in which the farthest DAC's word goes first.
REQ-027 csel SHALL stay low continuously from leaving IDLE until entering DONE, including across LOAD cycles.
REQ-028 sclk SHALL be low during every LOAD cycle.
REQ-029 DONE SHALL last 2 cycles with csel=1, sclk=0, mosi=0 and busy=1, then return to IDLE.
REQ-030 Timing SHALL be: busy high for 4×(1+128)+2 = 518 cycles; exactly 128 sclk rising edges; exactly 4 flush pulses per transaction.

Reset
REQ-031 reset=0 SHALL immediately force IDLE outputs: busy=0, csel=1, sclk=0, mosi=0, flush=0, addr=3, shift register cleared.
REQ-032 Reset mid-transaction SHALL abort with no further sclk edges or flush pulses.
REQ-033 After reset release, the block SHALL wait in IDLE for the next trig.

Verification
REQ-034 Words 0x00301111, 0x00302222, 0x00303333, 0x00304444 for addr 0-3, one trig -> csel low; 128 sclk rising edges; mosi at those edges gives 0x00304444, 0x00303333, 0x00302222, 0x00301111; busy 518 cycles; csel high.
REQ-035 Same transaction -> flush pulses one cycle each with addr=3, 2, 1, 0, each while busy=1, each 129 cycles apart.
REQ-036 Second trig 50 cycles into a transaction -> no effect: single 128-bit stream, busy still 518 cycles.
REQ-037 reset pulsed low mid-stream (e.g. bit 70) -> outputs go to idle values immediately; no further sclk/flush; next trig starts a fresh stream at addr=3.
REQ-038 Parent-model flush writes NOP (0x00F08000) to each word -> immediate retrigger shifts four NOP words.
REQ-039 sclk check -> high/low phases exactly 2 cycles each; mosi never changes while sclk is high.
